// File: rtl/leaf_stream_pkg.sv
// Shared types and default widths for the leaf stream stage.
package leaf_stream_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/leaf_stream_sat_cnt.sv
// Saturating up-counter with a sticky flag set when the count reaches all-ones.
module leaf_stream_sat_cnt
    import leaf_stream_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    // Count increments, holding at all-ones; flag sets on the edge that reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
            if (cnt == (MAX - W'(1))) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_stream_stage.sv
// Two-entry valid/ready skid buffer with a saturating transfer counter.
// Optional even-parity output enabled by defining LEAF_STREAM_PARITY_EN.
module leaf_stream_stage
    import leaf_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              cnt_sat
`ifdef LEAF_STREAM_PARITY_EN
    ,
    output logic              m_par
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] skid_q;
    logic              in_hs_c;
    logic              out_hs_c;
    logic              ld_main_in_c;
    logic              ld_main_skid_c;
    logic              ld_skid_c;
    logic              m_valid_d;
    logic              s_ready_d;

    assign in_hs_c  = s_valid && s_ready;
    assign out_hs_c = m_valid && m_ready;

    // Next state, register load selects and next registered handshake outputs.
    always_comb begin
        state_d        = state_q;
        ld_main_in_c   = 1'b0;
        ld_main_skid_c = 1'b0;
        ld_skid_c      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs_c) begin
                    ld_main_in_c = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (in_hs_c && out_hs_c) begin
                    ld_main_in_c = 1'b1;
                end else if (in_hs_c) begin
                    ld_skid_c = 1'b1;
                    state_d   = FULL;
                end else if (out_hs_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs_c) begin
                    ld_main_skid_c = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        m_valid_d = (state_d != EMPTY);
        s_ready_d = (state_d != FULL);
    end

    // State, handshake flags and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            m_data  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            m_valid <= m_valid_d;
            s_ready <= s_ready_d;
            if (ld_main_in_c) begin
                m_data <= s_data;
            end else if (ld_main_skid_c) begin
                m_data <= skid_q;
            end
            if (ld_skid_c) begin
                skid_q <= s_data;
            end
        end
    end

`ifdef LEAF_STREAM_PARITY_EN
    logic skid_par_q;

    // Parity bits travel with their words through main and skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_par      <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            if (ld_main_in_c) begin
                m_par <= ^s_data;
            end else if (ld_main_skid_c) begin
                m_par <= skid_par_q;
            end
            if (ld_skid_c) begin
                skid_par_q <= ^s_data;
            end
        end
    end
`endif

    leaf_stream_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs_c),
        .cnt   (xfer_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_leaf_stream_stage.sv
// Scoreboard bench for leaf_stream_stage: randomized and directed traffic,
// plus a narrow-counter instance for saturation.
module tb_leaf_stream_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, m_valid, m_ready, cnt_sat;
    logic [7:0]  s_data, m_data;
    logic [15:0] xfer_cnt;
    logic        s_valid2, s_ready2, m_valid2, cnt_sat2;
    logic        m_ready2;
    logic [7:0]  s_data2, m_data2;
    logic [1:0]  xfer_cnt2;
`ifdef LEAF_STREAM_PARITY_EN
    logic        m_par, m_par2;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    int          occ     = 0;
    int          exp_cnt = 0;
    bit          mon_en  = 1'b0;
    int          rdy_mode = 1;

    always #5 clk = ~clk;

    leaf_stream_stage #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .xfer_cnt (xfer_cnt),
        .cnt_sat  (cnt_sat)
`ifdef LEAF_STREAM_PARITY_EN
        ,
        .m_par    (m_par)
`endif
    );

    leaf_stream_stage #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid2),
        .s_ready  (s_ready2),
        .s_data   (s_data2),
        .m_valid  (m_valid2),
        .m_ready  (m_ready2),
        .m_data   (m_data2),
        .xfer_cnt (xfer_cnt2),
        .cnt_sat  (cnt_sat2)
`ifdef LEAF_STREAM_PARITY_EN
        ,
        .m_par    (m_par2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_ready();
        if (rdy_mode == 0)      m_ready = 1'b0;
        else if (rdy_mode == 1) m_ready = 1'b1;
        else                    m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_ready();
    endtask

    // Present one word until accepted; expected output queued when acceptance is seen.
    task automatic send(input logic [7:0] d, output int waited);
        s_valid = 1'b1;
        s_data  = d;
        waited  = 0;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(d);
                break;
            end
            waited++;
            if (waited > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: word 0x%0h not accepted after %0d cycles", d, waited);
                break;
            end
            step();
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        rdy_mode = 1;
        k = 0;
        while ((exp_q.size() != 0) && (k < 200)) begin
            step();
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words never delivered", exp_q.size());
        end
    endtask

    // Monitor: occupancy-derived handshake flags, in-order data, transfer count.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("m_valid", 32'(m_valid), 32'(occ != 0));
            check("s_ready", 32'(s_ready), 32'(occ < 2));
            check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
            check("cnt_sat", 32'(cnt_sat), 32'(0));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL m_data_unexpected: got 0x%0h expected nothing", m_data);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_q[0]));
`ifdef LEAF_STREAM_PARITY_EN
                    check("m_par", 32'(m_par), 32'(^exp_q[0]));
`endif
                end
            end
            if (s_valid && s_ready) occ++;
            if (m_valid && m_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                occ--;
                exp_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] rd;
        rst_n    = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        m_ready  = 1'b0;
        s_valid2 = 1'b0;
        s_data2  = 8'h00;
        m_ready2 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_s_ready", 32'(s_ready), 32'(1));
        check("rst_m_data", 32'(m_data), 32'(0));
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("rst_cnt_sat", 32'(cnt_sat), 32'(0));
`ifdef LEAF_STREAM_PARITY_EN
        check("rst_m_par", 32'(m_par), 32'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("idle_m_valid", 32'(m_valid), 32'(0));
        check("idle_s_ready", 32'(s_ready), 32'(1));
        check("idle_m_data", 32'(m_data), 32'(0));
        check("idle_xfer_cnt", 32'(xfer_cnt), 32'(0));
        step();
        mon_en = 1'b1;

        // Full-rate stream
        rdy_mode = 1;
        m_ready  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), w);
            check("stream_no_stall", 32'(w), 32'(0));
        end
        drain();
        @(negedge clk);
        check("stream_xfer_cnt", 32'(xfer_cnt), 32'(16));
        step();

        // Stall to FULL, third word refused, then release
        rdy_mode = 0;
        m_ready  = 1'b0;
        send(8'hA5, w);
        send(8'h5A, w);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_s_ready", 32'(s_ready), 32'(0));
            check("full_m_data_hold", 32'(m_data), 32'(8'hA5));
            step();
        end
        rdy_mode = 1;
        m_ready  = 1'b1;
        send(8'hFF, w);
        drain();

        // Parity-sensitive words
        send(8'h07, w);
        send(8'h03, w);
        drain();

        // Randomized traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) step();
            rd = 8'($urandom);
            send(rd, w);
        end
        drain();
        step();

        // Reset while FULL
        rdy_mode = 0;
        m_ready  = 1'b0;
        send(8'h11, w);
        send(8'h22, w);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'(0));
        check("midrst_s_ready", 32'(s_ready), 32'(1));
        check("midrst_m_data", 32'(m_data), 32'(0));
        check("midrst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("midrst_cnt_sat", 32'(cnt_sat), 32'(0));
        exp_q.delete();
        occ     = 0;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mon_en   = 1'b1;
        rdy_mode = 1;
        m_ready  = 1'b1;
        send(8'h3C, w);
        drain();
        @(negedge clk);
        check("postrst_xfer_cnt", 32'(xfer_cnt), 32'(1));
        step();

        // Narrow counter saturation on the second instance
        check("sat_rst_cnt", 32'(xfer_cnt2), 32'(0));
        for (int n = 1; n <= 5; n++) begin
            s_valid2 = 1'b1;
            s_data2  = 8'(n * 17);
            step();
            s_valid2 = 1'b0;
            step();
            @(negedge clk);
            check("sat_xfer_cnt", 32'(xfer_cnt2), 32'((n < 3) ? n : 3));
            check("sat_flag", 32'(cnt_sat2), 32'(n >= 3));
            step();
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
